// File: rtl/hazard_controller.sv
// Purpose: sequencing/hazard control for a 5-stage RV32I pipeline (enables, flushes, PC select, forwarding).
// Latency: all control outputs are combinational from inputs and shadow-stage state; mem_error/stall_cycles registered.
// Backpressure: a pending data-memory access freezes the pipe; a load-use hazard stalls IF/ID for one cycle.
module hazard_controller #(
    parameter int XLEN        = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_to_reg,
    input  logic                  ex_branch_taken,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    output logic                  pc_enable,
    output logic                  pc_sel_branch,
    output logic                  if_id_enable,
    output logic                  if_id_flush,
    output logic                  id_ex_enable,
    output logic                  id_ex_flush,
    output logic                  ex_mem_enable,
    output logic                  mem_wb_flush,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  mem_error,
    output logic [XLEN-1:0]       stall_cycles
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    // Register-use metadata carried alongside each in-flight instruction
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  is_load;
    } stage_t;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } mstate_t;

    stage_t            ex_s;
    stage_t            mem_s;
    stage_t            wb_s;
    mstate_t           state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              timeout;
    logic              freeze;
    logic              luh;
    logic              rs1_hit;
    logic              rs2_hit;

    // The last permitted wait cycle releases the freeze and completes the access as-is
    assign timeout = (state == MEM_WAIT) && (wait_cnt == WAIT_LAST);
    assign freeze  = dmem_req & ~dmem_ready & ~timeout;

    assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_s.rd);
    assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_s.rd);
    assign luh     = id_valid & ex_s.valid & ex_s.is_load & (ex_s.rd != '0) & (rs1_hit | rs2_hit);

    // Picks the youngest producer of src; loads in MEM have no data yet, x0 is never forwarded
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src,
                                           input stage_t mem_st,
                                           input stage_t wb_st);
        logic [1:0] sel;
        sel = 2'b00;
        if (mem_st.valid && mem_st.reg_write && (mem_st.rd != '0) &&
            (mem_st.rd == src) && !mem_st.is_load) begin
            sel = 2'b01;
        end else if (wb_st.valid && wb_st.reg_write && (wb_st.rd != '0) && (wb_st.rd == src)) begin
            sel = 2'b10;
        end
        return sel;
    endfunction

    assign fwd_a = fwd_sel(ex_s.rs1, mem_s, wb_s);
    assign fwd_b = fwd_sel(ex_s.rs2, mem_s, wb_s);

    // Priority resolution of pipeline controls: freeze > taken branch > load-use > run
    always_comb begin
        pc_enable     = 1'b0;
        pc_sel_branch = 1'b0;
        if_id_enable  = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_enable  = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_enable = 1'b0;
        mem_wb_flush  = 1'b0;
        if (reset) begin
            if (freeze) begin
                mem_wb_flush  = 1'b1;
            end else if (ex_branch_taken) begin
                pc_enable     = 1'b1;
                pc_sel_branch = 1'b1;
                if_id_enable  = 1'b1;
                if_id_flush   = 1'b1;
                id_ex_enable  = 1'b1;
                id_ex_flush   = 1'b1;
                ex_mem_enable = 1'b1;
            end else if (luh) begin
                // ID/EX stays enabled so the bubble actually lands in EX
                id_ex_enable  = 1'b1;
                id_ex_flush   = 1'b1;
                ex_mem_enable = 1'b1;
            end else begin
                pc_enable     = 1'b1;
                if_id_enable  = 1'b1;
                id_ex_enable  = 1'b1;
                ex_mem_enable = 1'b1;
            end
        end
    end

    // Shadow EX/MEM/WB stages follow the real pipeline registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex_s  <= '0;
            mem_s <= '0;
            wb_s  <= '0;
        end else begin
            if (id_ex_enable) begin
                if (id_ex_flush || !id_valid) begin
                    ex_s <= '0;
                end else begin
                    ex_s <= '{valid:     1'b1,
                              rs1:       id_rs1,
                              rs2:       id_rs2,
                              rd:        id_rd,
                              reg_write: id_reg_write,
                              is_load:   id_mem_to_reg};
                end
            end
            if (ex_mem_enable) begin
                mem_s <= ex_s;
            end
            wb_s <= mem_wb_flush ? '0 : mem_s;
        end
    end

    // Memory wait FSM: tracks an outstanding access and aborts it after MEM_TIMEOUT cycles
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_error <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (freeze) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (timeout) begin
                        mem_error <= 1'b1;
                        state     <= RUN;
                    end else if (!freeze) begin
                        state <= RUN;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Saturating count of cycles in which the PC did not advance
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (!pc_enable && (stall_cycles != {XLEN{1'b1}})) begin
            stall_cycles <= stall_cycles + XLEN'(1);
        end
    end

    // WB source fields are carried for completeness but nothing downstream reads them
    logic unused_wb;
    assign unused_wb = ^{wb_s.rs1, wb_s.rs2, wb_s.is_load};

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

    localparam logic [7:0] RUN_O = 8'b1010_1010;
    localparam logic [7:0] BR_O  = 8'b1111_1110;
    localparam logic [7:0] LUH_O = 8'b0000_1110;
    localparam logic [7:0] FRZ_O = 8'b0000_0001;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs1 = '0;
    logic [4:0]  id_rs2 = '0;
    logic        id_uses_rs1 = 1'b0;
    logic        id_uses_rs2 = 1'b0;
    logic [4:0]  id_rd = '0;
    logic        id_reg_write = 1'b0;
    logic        id_mem_to_reg = 1'b0;
    logic        ex_branch_taken = 1'b0;
    logic        dmem_req = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        pc_enable, pc_sel_branch, if_id_enable, if_id_flush;
    logic        id_ex_enable, id_ex_flush, ex_mem_enable, mem_wb_flush;
    logic [1:0]  fwd_a, fwd_b;
    logic        mem_error;
    logic [31:0] stall_cycles;

    int n_total = 0;
    int n_pass  = 0;

    hazard_controller dut (
        .clock(clock), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
        .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_enable(pc_enable), .pc_sel_branch(pc_sel_branch),
        .if_id_enable(if_id_enable), .if_id_flush(if_id_flush),
        .id_ex_enable(id_ex_enable), .id_ex_flush(id_ex_flush),
        .ex_mem_enable(ex_mem_enable), .mem_wb_flush(mem_wb_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_error(mem_error), .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        v;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  rd;
        logic        rw;
        logic        ld;
        logic        br;
        logic        req;
        logic        rdy;
        logic [7:0]  ctl;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] stall;
        logic        merr;
    } vec_t;

    typedef struct {
        int          id;
        logic [11:0] outs;
        logic [31:0] stall;
        logic        merr;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    int   row_id = 0;

    function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                                input logic rw, input logic ld, input logic br,
                                input logic req, input logic rdy, input logic [7:0] ctl,
                                input logic [1:0] fa, input logic [1:0] fb,
                                input logic [31:0] stall, input logic merr);
        vec_t r;
        r.v = v; r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2; r.rd = rd;
        r.rw = rw; r.ld = ld; r.br = br; r.req = req; r.rdy = rdy;
        r.ctl = ctl; r.fa = fa; r.fb = fb; r.stall = stall; r.merr = merr;
        return r;
    endfunction

    task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s row %0d: got %h expected %h", nm, id, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare at the falling edge
    task automatic apply(input vec_t r);
        exp_t e;
        exp_t g;
        @(posedge clock);
        #1;
        id_valid = r.v; id_rs1 = r.rs1; id_uses_rs1 = r.u1; id_rs2 = r.rs2; id_uses_rs2 = r.u2;
        id_rd = r.rd; id_reg_write = r.rw; id_mem_to_reg = r.ld;
        ex_branch_taken = r.br; dmem_req = r.req; dmem_ready = r.rdy;
        e.id = row_id; e.outs = {r.ctl, r.fa, r.fb}; e.stall = r.stall; e.merr = r.merr;
        exp_q.push_back(e);
        row_id++;
        @(negedge clock);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", row_id, 32'd0, 32'd1);
        end else begin
            g = exp_q.pop_front();
            check("ctl_fwd", g.id,
                  32'({pc_enable, pc_sel_branch, if_id_enable, if_id_flush, id_ex_enable,
                       id_ex_flush, ex_mem_enable, mem_wb_flush, fwd_a, fwd_b}),
                  32'(g.outs));
            check("stall_cycles", g.id, stall_cycles, g.stall);
            check("mem_error", g.id, 32'(mem_error), 32'(g.merr));
        end
    endtask

    initial begin
        // Reset state
        #3;
        check("reset_outs", -1,
              32'({pc_enable, pc_sel_branch, if_id_enable, if_id_flush, id_ex_enable,
                   id_ex_flush, ex_mem_enable, mem_wb_flush, fwd_a, fwd_b}), 32'd0);
        check("reset_stall", -1, stall_cycles, 32'd0);
        check("reset_merr", -1, 32'(mem_error), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        //          v  rs1 u1 rs2 u2 rd rw ld br rq rdy ctl    fa     fb     stall merr
        // back-to-back dependency: x5 -> x6 (MEM fwd) -> x9 (WB fwd)
        tbl.push_back(mk(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, RUN_O, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(1, 5, 1, 3, 1, 6, 1, 0, 0, 0, 0, RUN_O, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(1, 5, 1, 4, 1, 9, 1, 0, 0, 0, 0, RUN_O, 2'b01, 2'b00, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN_O, 2'b10, 2'b00, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN_O, 2'b00, 2'b00, 0, 0));
        // load-use: lw x7 ; add x8,x7,x1 held one cycle
        tbl.push_back(mk(1, 2, 1, 0, 0, 7, 1, 1, 0, 0, 0, RUN_O, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(1, 7, 1, 1, 1, 8, 1, 0, 0, 0, 0, LUH_O, 2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(1, 7, 1, 1, 1, 8, 1, 0, 0, 0, 0, RUN_O, 2'b00, 2'b00, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN_O, 2'b10, 2'b00, 1, 0));
        // taken branch while a load-use hazard sits in ID
        tbl.push_back(mk(1, 1, 1, 0, 0, 10, 1, 1, 0, 0, 0, RUN_O, 2'b00, 2'b00, 1, 0));
        tbl.push_back(mk(1, 10, 1, 10, 1, 11, 1, 0, 1, 0, 0, BR_O, 2'b00, 2'b00, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN_O, 2'b00, 2'b00, 1, 0));
        // x0 writers and readers: no forwarding, no load-use stall
        tbl.push_back(mk(1, 1, 1, 2, 1, 0, 1, 0, 0, 0, 0, RUN_O, 2'b00, 2'b00, 1, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, RUN_O, 2'b00, 2'b00, 1, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 12, 1, 0, 0, 0, 0, RUN_O, 2'b00, 2'b00, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN_O, 2'b00, 2'b00, 1, 0));
        // x13 reads x12 (in WB when the freeze starts); freeze flushes WB, holds EX/MEM
        tbl.push_back(mk(1, 12, 1, 12, 1, 13, 1, 0, 0, 0, 0, RUN_O, 2'b00, 2'b00, 1, 0));
        tbl.push_back(mk(1, 13, 1, 13, 1, 14, 1, 0, 0, 1, 0, FRZ_O, 2'b10, 2'b10, 1, 0));
        tbl.push_back(mk(1, 13, 1, 13, 1, 14, 1, 0, 0, 1, 0, FRZ_O, 2'b00, 2'b00, 2, 0));
        tbl.push_back(mk(1, 13, 1, 13, 1, 14, 1, 0, 0, 1, 0, FRZ_O, 2'b00, 2'b00, 3, 0));
        tbl.push_back(mk(1, 13, 1, 13, 1, 14, 1, 0, 0, 1, 1, RUN_O, 2'b00, 2'b00, 4, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN_O, 2'b01, 2'b01, 4, 0));

        foreach (tbl[i]) apply(tbl[i]);

        // Memory timeout: 16 frozen cycles, one released cycle, then sticky mem_error
        for (int i = 0; i < 16; i++) begin
            apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ_O, 2'b00, 2'b00, 32'(4 + i), 0));
        end
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, RUN_O, 2'b00, 2'b00, 20, 0));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN_O, 2'b00, 2'b00, 20, 1));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN_O, 2'b00, 2'b00, 20, 1));

        // Reset in the middle of a wait abandons the access and clears the counters
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ_O, 2'b00, 2'b00, 20, 1));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ_O, 2'b00, 2'b00, 21, 1));
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("midwait_reset_outs", row_id,
              32'({pc_enable, pc_sel_branch, if_id_enable, if_id_flush, id_ex_enable,
                   id_ex_flush, ex_mem_enable, mem_wb_flush, fwd_a, fwd_b}), 32'd0);
        check("midwait_reset_stall", row_id, stall_cycles, 32'd0);
        check("midwait_reset_merr", row_id, 32'(mem_error), 32'd0);
        @(negedge clock);
        dmem_req = 1'b0;
        reset = 1'b1;

        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, RUN_O, 2'b00, 2'b00, 0, 0));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ_O, 2'b00, 2'b00, 0, 0));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, RUN_O, 2'b00, 2'b00, 1, 0));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN_O, 2'b00, 2'b00, 1, 0));

        if (exp_q.size() != 0) begin
            check("scoreboard_drained", row_id, 32'(exp_q.size()), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
